modexp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one modular-exponentiation engine (`modularmult` interface: M, e, n, start, finished, remainder) among NUM_REQ requesters.
- Accepts a request (M, e, n) and screens operands; trivial and illegal cases are answered without the engine.
- Pulses the engine start and masks the engine's stale `finished` flag.
- Captures the remainder and returns it to the granted requester.
- Sits between the SHA/RSA control front-end and the exponentiation datapath.

---
 rtl/modexp_arbiter_pkg.sv | 16 +
 rtl/modexp_arbiter_if.sv | 38 +++
 rtl/modexp_arbiter_rr_arbiter.sv | 31 +++
 rtl/modexp_arbiter.sv | 118 +++++++++++
 tb/tb_modexp_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/modexp_arbiter_pkg.sv
// Shared types and constants for the modexp arbiter slice.
// State encoding, default operand width and largest modulus the engine can take.
package modexp_pkg;

  localparam int DEF_W   = 16;
  localparam int MAX_MOD = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/modexp_arbiter_if.sv
// Requester, response and engine signals of the modexp arbiter in one bundle.
// slave = arbiter side, master = requesters plus engine.
interface modexp_arbiter_if
  import modexp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = DEF_W
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_M;
  logic [NUM_REQ*W-1:0] req_e;
  logic [NUM_REQ*W-1:0] req_n;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [W-1:0]         rsp_data;
  logic                 rsp_err;
  logic                 busy;
  logic [W-1:0]         eng_M;
  logic [W-1:0]         eng_e;
  logic [W-1:0]         eng_n;
  logic                 eng_start;
  logic                 eng_finished;
  logic [W-1:0]         eng_remainder;

  modport slave (
    input  req_valid, req_M, req_e, req_n, eng_finished, eng_remainder,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy,
           eng_M, eng_e, eng_n, eng_start
  );

  modport master (
    output req_valid, req_M, req_e, req_n, eng_finished, eng_remainder,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
           eng_M, eng_e, eng_n, eng_start
  );

endinterface

// File: rtl/modexp_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
// Zero latency; no state, no backpressure.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  logic [PW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = PW'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/modexp_arbiter.sv
// Shares one modexp engine among NUM_REQ requesters; screens trivial/illegal operands.
// Response 1 cycle after accept (bypass/err) or max(4,e+2) via engine; no response backpressure.
module modexp_arbiter
  import modexp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  modexp_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t              r_state, w_nxt;
  logic [PW-1:0]       r_ptr, r_owner;
  logic [W-1:0]        r_M, r_e, r_n, r_result;
  logic                r_err;
  logic [CW-1:0]       r_cnt;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [PW-1:0]       w_idx, w_ptr_nxt;
  logic                w_any, w_accept, w_scr_err, w_bypass, w_timeout;
  logic [W-1:0]        w_M, w_e, w_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Screening uses the winner's live operands, before they are registered.
  assign w_M       = bus.req_M[int'(w_idx)*W +: W];
  assign w_e       = bus.req_e[int'(w_idx)*W +: W];
  assign w_n       = bus.req_n[int'(w_idx)*W +: W];
  assign w_scr_err = (w_n == '0) || (w_n > W'(MAX_MOD)) || (w_M >= w_n);
  assign w_bypass  = (w_e == '0);
  assign w_accept  = (r_state == ST_IDLE) && w_any;
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign w_ptr_nxt = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + PW'(1);

  always_comb begin
    w_nxt         = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    bus.busy      = (r_state != ST_IDLE);
    bus.eng_start = 1'b0;
    bus.eng_M     = r_M;
    bus.eng_e     = r_e;
    bus.eng_n     = r_n;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = w_gnt;
        if (w_accept) w_nxt = (w_scr_err || w_bypass) ? ST_RESP : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        bus.eng_start = 1'b1;
        w_nxt         = ST_SETTLE;
      end
      // eng_finished still reflects the previous job here.
      ST_SETTLE: w_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.eng_finished || w_timeout) w_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = NUM_REQ'(1) << r_owner;
        bus.rsp_data  = r_err ? '0 : r_result;
        bus.rsp_err   = r_err;
        w_nxt         = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_M      <= '0;
      r_e      <= '0;
      r_n      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ptr    <= w_ptr_nxt;
            r_owner  <= w_idx;
            r_M      <= w_M;
            r_e      <= w_e;
            r_n      <= w_n;
            r_err    <= w_scr_err;
            r_result <= (w_bypass && !w_scr_err) ? W'(w_n != W'(1)) : '0;
            r_cnt    <= '0;
          end
        end
        ST_WAIT: begin
          if (bus.eng_finished) r_result <= bus.eng_remainder;
          else if (w_timeout)   r_err    <= 1'b1;
          else                  r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_arbiter.sv
// Directed bench for modexp_arbiter with a cycle-level engine model that can be held stalled.
// Expected values are hand-computed from the operands.
module tb_modexp_arbiter;
  import modexp_pkg::*;

  localparam int NR = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  modexp_arbiter_if #(.NUM_REQ(NR), .W(W)) bus ();

  modexp_arbiter #(.NUM_REQ(NR), .W(W), .TIMEOUT(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Engine: ncount loads e-1 at start, counts down; finished while ncount==0.
  logic [W-1:0] ncount  = '0;
  logic [W-1:0] eng_rem = '0;
  logic         stall   = 1'b0;
  always @(posedge clk) begin
    if (bus.eng_start) begin
      ncount  <= bus.eng_e - W'(1);
      eng_rem <= bus.eng_M;
    end else if (ncount != '0) begin
      ncount <= ncount - W'(1);
      if (bus.eng_n != '0)
        eng_rem <= W'((32'(eng_rem) * 32'(bus.eng_M)) % 32'(bus.eng_n));
    end
  end
  assign bus.eng_finished  = (ncount == '0) && !stall;
  assign bus.eng_remainder = eng_rem;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] m, input logic [W-1:0] e,
                         input logic [W-1:0] n);
    bus.req_M[i*W +: W] = m;
    bus.req_e[i*W +: W] = e;
    bus.req_n[i*W +: W] = n;
  endtask

  // Issue one request from an IDLE cycle and check latency, data, error and start pulses.
  task automatic job(input string tag, input int i, input logic [W-1:0] m,
                     input logic [W-1:0] e, input logic [W-1:0] n, input int exp_lat,
                     input logic [W-1:0] exp_data, input logic exp_err, input int exp_starts);
    int lat, starts, first_start;
    logic [NR-1:0] vmask;
    logic [W-1:0]  data;
    logic          err;
    lat = -1; starts = 0; first_start = -1; vmask = '0; data = '0; err = 1'b0;
    set_ops(i, m, e, n);
    bus.req_valid[i] = 1'b1;
    #1;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(1) << i);
    tick();
    bus.req_valid[i] = 1'b0;
    for (int off = 1; off <= 40; off++) begin
      if (bus.eng_start) begin
        starts++;
        if (first_start < 0) first_start = off;
      end
      if (|bus.rsp_valid) begin
        lat = off; vmask = bus.rsp_valid; data = bus.rsp_data; err = bus.rsp_err;
        break;
      end
      tick();
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".owner"}, 32'(vmask), 32'(1) << i);
    chk({tag, ".data"}, 32'(data), 32'(exp_data));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".starts"}, 32'(starts), 32'(exp_starts));
    if (exp_starts > 0) chk({tag, ".start_cyc"}, 32'(first_start), 32'(1));
    tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_M     = '0;
    bus.req_e     = '0;
    bus.req_n     = '0;

    tick();
    tick();
    chk("rst.busy", 32'(bus.busy), 32'(0));
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst.eng_start", 32'(bus.eng_start), 32'(0));
    chk("rst.eng_M", 32'(bus.eng_M), 32'(0));
    chk("rst.rsp_data", 32'(bus.rsp_data), 32'(0));
    reset = 1'b1;
    tick();

    // 5^3 mod 13 = 8, 7^1 mod 11 = 7
    job("eng0", 0, 16'd5, 16'd3, 16'd13, 5, 16'd8, 1'b0, 1);
    job("eng1", 1, 16'd7, 16'd1, 16'd11, 4, 16'd7, 1'b0, 1);
    job("byp_n11", 2, 16'd3, 16'd0, 16'd11, 1, 16'd1, 1'b0, 0);
    job("byp_n1", 2, 16'd0, 16'd0, 16'd1, 1, 16'd0, 1'b0, 0);
    job("err_n0", 3, 16'd0, 16'd5, 16'd0, 1, 16'd0, 1'b1, 0);
    job("err_n300", 3, 16'd5, 16'd2, 16'd300, 1, 16'd0, 1'b1, 0);
    job("err_MgeN", 3, 16'd20, 16'd2, 16'd13, 1, 16'd0, 1'b1, 0);

    // All four contend; pointer is back at 0, so order is 0,1,2,3. Result k+2 tags the owner.
    for (int k = 0; k < NR; k++) set_ops(k, W'(k + 2), 16'd1, 16'd11);
    bus.req_valid = '1;
    #1;
    for (int k = 0; k < NR; k++) begin
      logic got;
      got = 1'b0;
      chk("rr.grant", 32'(bus.req_ready), 32'(1) << k);
      tick();
      bus.req_valid[k] = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (|bus.rsp_valid) begin
          got = 1'b1;
          chk("rr.owner", 32'(bus.rsp_valid), 32'(1) << k);
          chk("rr.data", 32'(bus.rsp_data), 32'(k + 2));
          break;
        end
        tick();
      end
      chk("rr.resp_seen", 32'(got), 32'(1));
      tick();
    end

    // Pointer must have wrapped to 0: requester 0 beats 1.
    set_ops(0, 16'd2, 16'd0, 16'd11);
    set_ops(1, 16'd2, 16'd0, 16'd11);
    bus.req_valid = 4'b0011;
    #1;
    chk("wrap.grant0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    chk("wrap.rsp0", 32'(bus.rsp_valid), 32'b0001);
    tick();
    chk("wrap.grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    chk("wrap.rsp1", 32'(bus.rsp_valid), 32'b0010);
    tick();

    // Engine never finishes: accept A, WAIT from A+3 for 20 cycles, response in A+23.
    stall = 1'b1;
    job("tmo", 0, 16'd5, 16'd3, 16'd13, 23, 16'd0, 1'b1, 1);
    stall = 1'b0;

    // Reset while waiting on a long job from requester 1.
    set_ops(1, 16'd2, 16'd10, 16'd13);
    bus.req_valid[1] = 1'b1;
    #1;
    chk("rstw.ready", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    tick();
    tick();
    chk("rstw.busy_before", 32'(bus.busy), 32'(1));
    reset = 1'b0;
    tick();
    chk("rstw.busy", 32'(bus.busy), 32'(0));
    chk("rstw.rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rstw.eng_start", 32'(bus.eng_start), 32'(0));
    chk("rstw.eng_ops", 32'({bus.eng_M, bus.eng_e} | 32'(bus.eng_n)), 32'(0));
    chk("rstw.rsp_data", 32'({bus.rsp_err, bus.rsp_data}), 32'(0));
    chk("rstw.req_ready", 32'(bus.req_ready), 32'(0));
    reset = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int c = 0; c < 15; c++) begin
        tick();
        if (|bus.rsp_valid) stray++;
      end
      chk("rstw.no_rsp", 32'(stray), 32'(0));
    end
    job("after_rst", 0, 16'd5, 16'd3, 16'd13, 5, 16'd8, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
